// File: rtl/regbank_param.sv
// rtl/regbank_param.sv - parametrised CSR bank with per-register access types, one write port, NUM_RD read ports
module regbank_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 10,
    parameter int NUM_RD     = 2,
    parameter logic [NUM_REGS*3-1:0]          ACC_TYPES = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VALS  = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic [DATA_WIDTH/8-1:0]        wr_be_i,
    output logic                           wr_err_o,
    input  logic [NUM_RD-1:0]              rd_req_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [NUM_RD-1:0]              rd_valid_o,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]              rd_err_o,
    input  logic [NUM_REGS-1:0]            hw_we_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_data_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [2:0] T_RW = 3'd0, T_RO = 3'd1, T_RC = 3'd2, T_WO = 3'd3,
                           T_W1C = 3'd4, T_W1S = 3'd5, T_WONCE = 3'd6;

    function automatic logic [31:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a[ADDR_WIDTH-1:2]);
    endfunction

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (addr_idx(a) < 32'(NUM_REGS));
    endfunction

    function automatic logic [2:0] acc(input int i);
        return ACC_TYPES[3*i +: 3];
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   lock_q, lock_d;
    logic [DATA_WIDTH-1:0] rd_data_q [NUM_RD];
    logic [DATA_WIDTH-1:0] rd_data_d [NUM_RD];
    logic [NUM_RD-1:0]     rd_valid_q, rd_err_q, rd_err_d;
    logic                  wr_err_q, wr_err_d;
    logic [NUM_REGS-1:0]   rc_clr;
    logic [DATA_WIDTH-1:0] be_mask;
    logic [DATA_WIDTH-1:0] wdata_m;
    logic                  wr_ok;

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < NB; b++) begin
            be_mask[8*b +: 8] = {8{wr_be_i[b]}};
        end
        wdata_m  = wr_data_i & be_mask;
        wr_ok    = wr_en_i && addr_ok(wr_addr_i);
        wr_err_d = wr_en_i && !wr_ok;
        rc_clr   = '0;

        // Every port hitting an RC register sees the pre-clear value; the clear happens once.
        for (int p = 0; p < NUM_RD; p++) begin
            rd_err_d[p]  = rd_req_i[p] && !addr_ok(rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
            rd_data_d[p] = rd_data_q[p];
            if (rd_req_i[p]) begin
                rd_data_d[p] = '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr_ok(rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]) &&
                        addr_idx(rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]) == 32'(i)) begin
                        if (acc(i) != T_WO && acc(i) != T_W1C && acc(i) != T_W1S) begin
                            rd_data_d[p] = regs_q[i];
                        end
                        if (acc(i) == T_RC) begin
                            rc_clr[i] = 1'b1;
                        end
                    end
                end
            end
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            lock_d[i] = lock_q[i];
            if (wr_ok && addr_idx(wr_addr_i) == 32'(i)) begin
                case (acc(i))
                    T_RW, T_WO: regs_d[i] = (regs_q[i] & ~be_mask) | wdata_m;
                    T_W1C:      regs_d[i] = regs_q[i] & ~wdata_m;
                    T_W1S:      regs_d[i] = regs_q[i] | wdata_m;
                    T_WONCE: begin
                        if (lock_q[i]) begin
                            wr_err_d = 1'b1;
                        end else begin
                            regs_d[i] = (regs_q[i] & ~be_mask) | wdata_m;
                            lock_d[i] = 1'b1;
                        end
                    end
                    default:    wr_err_d = 1'b1;
                endcase
            end
            // Hardware updates land after the software op so new events are never lost.
            case (acc(i))
                T_RO: if (hw_we_i[i]) regs_d[i] = hw_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                T_RC: begin
                    if (rc_clr[i]) begin
                        regs_d[i] = hw_we_i[i] ? hw_data_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                    end else if (hw_we_i[i]) begin
                        regs_d[i] = regs_q[i] | hw_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                T_W1C, T_W1S: if (hw_we_i[i]) regs_d[i] = regs_d[i] | hw_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_VALS[i*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data_q[p] <= '0;
            end
            lock_q     <= '0;
            rd_valid_q <= '0;
            rd_err_q   <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data_q[p] <= rd_data_d[p];
            end
            lock_q     <= lock_d;
            rd_valid_q <= rd_req_i;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        reg_q_o   = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[p];
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign wr_err_o   = wr_err_q;
endmodule

// File: tb/tb_regbank_param.sv
// tb/tb_regbank_param.sv - self-checking bench for regbank_param against a byte-level behavioural model
module tb_regbank_param;
    localparam int NR = 10;
    localparam int NP = 2;

    logic         clk, rst;
    logic         wr_en;
    logic [7:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [3:0]   wr_be;
    logic         wr_err;
    logic [NP-1:0]    rd_req, rd_valid, rd_err;
    logic [NP*8-1:0]  rd_addr;
    logic [NP*32-1:0] rd_data;
    logic [NR-1:0]    hw_we;
    logic [NR*32-1:0] hw_data, reg_q;

    // reg0 RW, reg1 RO, reg2 RC, reg3 RW, reg4 WO, reg5 RO, reg6 RW, reg7 W1C, reg8 W1S, reg9 WONCE
    regbank_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(NR), .NUM_RD(NP),
        .ACC_TYPES({3'd6, 3'd5, 3'd4, 3'd0, 3'd1, 3'd3, 3'd0, 3'd2, 3'd1, 3'd0}),
        .RST_VALS({32'h0, 32'hF0, 32'hFF, 32'h66, 32'h55, 32'h44, 32'h0, 32'h0, 32'hCAFE0001, 32'h0})
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be), .wr_err_o(wr_err),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_err_o(rd_err),
        .hw_we_i(hw_we), .hw_data_i(hw_data), .reg_q_o(reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [31:0] m_reg [NR];
    bit          m_lock [NR];
    bit          m_valid [NP];
    bit          m_err [NP];
    logic [31:0] m_data [NP];
    bit          m_wr_err;

    function automatic int ty(input int i);
        case (i)
            1, 5:    return 1;
            2:       return 2;
            4:       return 3;
            7:       return 4;
            8:       return 5;
            9:       return 6;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] rv(input int i);
        case (i)
            1:       return 32'hCAFE0001;
            4:       return 32'h44;
            5:       return 32'h55;
            6:       return 32'h66;
            7:       return 32'hFF;
            8:       return 32'hF0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = rv(i);
            m_lock[i] = 0;
        end
        for (int p = 0; p < NP; p++) begin
            m_valid[p] = 0;
            m_err[p]   = 0;
            m_data[p]  = '0;
        end
        m_wr_err = 0;
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_req = '0; rd_addr = '0; hw_we = '0; hw_data = '0;
    endtask

    // Computes the post-edge state from the current inputs, then advances one clock.
    task automatic tick();
        logic [31:0] nreg [NR];
        bit          nlock [NR];
        bit          clr [NR];
        bit          nvalid [NP];
        bit          nerr [NP];
        logic [31:0] ndata [NP];
        bit          nwerr;
        int          r;
        logic [7:0]  a;
        logic [7:0]  ob, db;
        for (int i = 0; i < NR; i++) begin
            nreg[i] = m_reg[i]; nlock[i] = m_lock[i]; clr[i] = 0;
        end
        nwerr = 0;
        for (int p = 0; p < NP; p++) begin
            a = rd_addr[p*8 +: 8];
            nvalid[p] = rd_req[p];
            nerr[p]   = 0;
            ndata[p]  = m_data[p];
            if (rd_req[p]) begin
                if (a % 4 != 0 || a / 4 >= NR) begin
                    nerr[p]  = 1;
                    ndata[p] = '0;
                end else begin
                    r = a / 4;
                    ndata[p] = (ty(r) == 3 || ty(r) == 4 || ty(r) == 5) ? 32'h0 : m_reg[r];
                    if (ty(r) == 2) clr[r] = 1;
                end
            end
        end
        if (wr_en) begin
            if (wr_addr % 4 != 0 || wr_addr / 4 >= NR) begin
                nwerr = 1;
            end else begin
                r = wr_addr / 4;
                if (ty(r) == 1 || ty(r) == 2 || (ty(r) == 6 && m_lock[r])) begin
                    nwerr = 1;
                end else begin
                    if (ty(r) == 6) nlock[r] = 1;
                    for (int b = 0; b < 4; b++) begin
                        if (wr_be[b]) begin
                            ob = m_reg[r][8*b +: 8];
                            db = wr_data[8*b +: 8];
                            case (ty(r))
                                4:       nreg[r][8*b +: 8] = ob & ~db;
                                5:       nreg[r][8*b +: 8] = ob | db;
                                default: nreg[r][8*b +: 8] = db;
                            endcase
                        end
                    end
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (clr[i]) nreg[i] = '0;
            if (hw_we[i]) begin
                if (ty(i) == 1) nreg[i] = hw_data[i*32 +: 32];
                else if (ty(i) == 2 || ty(i) == 4 || ty(i) == 5) nreg[i] = nreg[i] | hw_data[i*32 +: 32];
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            m_reg[i] = nreg[i]; m_lock[i] = nlock[i];
        end
        for (int p = 0; p < NP; p++) begin
            m_valid[p] = nvalid[p]; m_err[p] = nerr[p]; m_data[p] = ndata[p];
        end
        m_wr_err = nwerr;
    endtask

    task automatic do_write(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] be);
        idle(); wr_en = 1; wr_addr = ad; wr_data = d; wr_be = be;
        tick(); idle();
    endtask

    task automatic do_read(input int p, input logic [7:0] ad);
        idle(); rd_req[p] = 1; rd_addr[p*8 +: 8] = ad;
        tick(); idle();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_err", 32'(wr_err), 32'(m_wr_err));
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("rd_valid[%0d]", p), 32'(rd_valid[p]), 32'(m_valid[p]));
                chk($sformatf("rd_err[%0d]", p), 32'(rd_err[p]), 32'(m_err[p]));
                chk($sformatf("rd_data[%0d]", p), rd_data[p*32 +: 32], m_data[p]);
            end
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("reg_q[%0d]", i), reg_q[i*32 +: 32], m_reg[i]);
            end
        end
    end

    initial begin
        rst = 1;
        idle();
        model_reset();
        chk_en = 1;
        @(posedge clk);
        #3 rst = 0;
        tick();

        // T1: read every register on port 0, back to back
        idle();
        rd_req[0] = 1;
        for (int i = 0; i < NR; i++) begin
            rd_addr[7:0] = 8'(4 * i);
            tick();
            chk("t1_valid", 32'(rd_valid[0]), 32'd1);
            if (i == 1) chk("t1_reg1", rd_data[31:0], 32'hCAFE0001);
            if (i == 4) chk("t1_wo_reads0", rd_data[31:0], 32'h0);
            if (i == 6) chk("t1_reg6", rd_data[31:0], 32'h66);
        end
        idle();
        tick();
        chk("t1_valid_drop", 32'(rd_valid[0]), 32'd0);

        // T2: byte-enabled RW write, misaligned write, RO write and hw load, bad read address
        do_write(8'h00, 32'hAABBCCDD, 4'b0101);
        chk("t2_reg0", reg_q[31:0], 32'h00BB00DD);
        do_write(8'h29, 32'h12345678, 4'hF);
        chk("t2_bad_wr_err", 32'(wr_err), 32'd1);
        chk("t2_reg0_kept", reg_q[31:0], 32'h00BB00DD);
        do_write(8'h04, 32'h1, 4'hF);
        chk("t2_ro_wr_err", 32'(wr_err), 32'd1);
        hw_we[1] = 1; hw_data[63:32] = 32'h77;
        tick(); idle();
        chk("t2_ro_hw", reg_q[63:32], 32'h77);
        do_read(1, 8'h28);
        chk("t2_rd_err", 32'(rd_err[1]), 32'd1);
        chk("t2_rd_err_data", rd_data[63:32], 32'h0);

        // T3: RC read-clear from two ports, then hw set colliding with a clear
        hw_we[2] = 1; hw_data[95:64] = 32'h5;
        tick(); idle();
        rd_req = 2'b11; rd_addr = {8'h08, 8'h08};
        tick(); idle();
        chk("t3_p0", rd_data[31:0], 32'h5);
        chk("t3_p1", rd_data[63:32], 32'h5);
        chk("t3_cleared", reg_q[95:64], 32'h0);
        do_read(0, 8'h08);
        chk("t3_reread", rd_data[31:0], 32'h0);
        rd_req[0] = 1; rd_addr[7:0] = 8'h08; hw_we[2] = 1; hw_data[95:64] = 32'h2;
        tick(); idle();
        chk("t3_collide_rd", rd_data[31:0], 32'h0);
        chk("t3_collide_reg", reg_q[95:64], 32'h2);
        rd_addr[7:0] = 8'h08;
        tick();
        chk("t3_addr_no_clear", reg_q[95:64], 32'h2);

        // T4: W1C and W1S, both read as zero
        do_write(8'h1C, 32'h0F, 4'hF);
        chk("t4_w1c", reg_q[255:224], 32'hF0);
        do_write(8'h20, 32'h03, 4'hF);
        chk("t4_w1s", reg_q[287:256], 32'hF3);
        rd_req = 2'b11; rd_addr = {8'h20, 8'h1C};
        tick(); idle();
        chk("t4_rd_w1c", rd_data[31:0], 32'h0);
        chk("t4_rd_w1s", rd_data[63:32], 32'h0);

        // T5: write-once lock and its release by reset
        do_write(8'h24, 32'h1234, 4'hF);
        chk("t5_first", reg_q[319:288], 32'h1234);
        do_write(8'h24, 32'h5678, 4'hF);
        chk("t5_locked", reg_q[319:288], 32'h1234);
        chk("t5_locked_err", 32'(wr_err), 32'd1);
        #2 rst = 1; model_reset();
        @(posedge clk);
        #3 rst = 0;
        tick();
        do_write(8'h24, 32'h5678, 4'hF);
        chk("t5_after_rst", reg_q[319:288], 32'h5678);
        chk("t5_after_rst_err", 32'(wr_err), 32'd0);

        // T6: same-edge write/read of reg3, then reset during a live read
        wr_en = 1; wr_addr = 8'h0C; wr_data = 32'h1; wr_be = 4'hF;
        rd_req[0] = 1; rd_addr[7:0] = 8'h0C;
        tick(); idle();
        chk("t6_old", rd_data[31:0], 32'h0);
        do_read(0, 8'h0C);
        chk("t6_new", rd_data[31:0], 32'h1);
        rd_req[0] = 1; rd_addr[7:0] = 8'h0C;
        tick();
        chk("t6_valid_before_rst", 32'(rd_valid[0]), 32'd1);
        #2 rst = 1; model_reset(); idle();
        #1 chk("t6_rst_drop", 32'(rd_valid[0]), 32'd0);
        @(posedge clk);
        #1 chk("t6_rst_hold", 32'(rd_valid[0]), 32'd0);
        #2 rst = 0;
        tick();
        tick();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
